// File: rtl/stream_byte_packer.sv
// Byte packer: squeezes sparse AXI-stream beats (contiguous tkeep prefix) into
// gap-free output beats, flushing a short final beat at each packet end.

module stream_byte_packer_slot #(
  parameter int DATA_BYTES = 32,
  parameter int IDX        = 0,
  parameter int CW         = 7
) (
  input  logic [2*DATA_BYTES-1:0][7:0] buf_q,
  input  logic [DATA_BYTES-1:0][7:0]   din,
  input  logic [CW-1:0]                shift,
  input  logic [CW-1:0]                base,
  input  logic [CW-1:0]                n,
  input  logic                         accept,
  output logic [7:0]                   nxt
);
  localparam int AW = $clog2(2*DATA_BYTES);
  localparam int DW = $clog2(DATA_BYTES);

  int src;
  int off;

  // Each buffer slot takes either the byte shifted down by the pop, or a
  // freshly accepted byte landing just above the surviving fill.
  always_comb begin
    src = IDX + int'(shift);
    off = IDX - int'(base);
    nxt = 8'h00;
    if (src < 2*DATA_BYTES) nxt = buf_q[AW'(src)];
    if (accept && off >= 0 && off < int'(n)) nxt = din[DW'(off)];
  end
endmodule

module stream_byte_packer #(
  parameter int DATA_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wrt_en,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic [DATA_BYTES-1:0]   tkeep_in,
  input  logic                    tvalid_in,
  input  logic                    tlast_in,
  output logic                    tready_out,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic [DATA_BYTES-1:0]   tkeep_out,
  output logic                    tvalid_out,
  output logic                    tlast_out,
  input  logic                    tready_in
);
  localparam int CW = $clog2(2*DATA_BYTES+1);
  localparam logic [CW-1:0] DB_C = CW'(DATA_BYTES);

  logic [2*DATA_BYTES-1:0][7:0] buf_q, buf_d;
  logic [CW-1:0]                fill_q, fill_d;
  logic                         flush_q, flush_d;
  logic [CW-1:0]                n_in, pop_cnt, base;
  logic                         run, final_beat, accept, pop;

  always_comb begin
    n_in = '0;
    run  = 1'b1;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (run && tkeep_in[i]) n_in = n_in + CW'(1);
      else                    run  = 1'b0;
    end
  end

  // Async reset gates the handshake outputs so they read 0 while held.
  assign final_beat = flush_q && (fill_q <= DB_C);
  assign tvalid_out = reset && wrt_en && ((fill_q >= DB_C) || flush_q);
  assign tready_out = reset && wrt_en && !flush_q && (fill_q <= DB_C);
  assign tlast_out  = tvalid_out && final_beat;
  assign data_out   = buf_q[DATA_BYTES-1:0];

  always_comb begin
    for (int i = 0; i < DATA_BYTES; i++)
      tkeep_out[i] = tvalid_out && (!final_beat || (CW'(i) < fill_q));
  end

  assign accept  = tvalid_in && tready_out;
  assign pop     = tvalid_out && tready_in;
  assign pop_cnt = pop ? (final_beat ? fill_q : DB_C) : '0;
  assign base    = fill_q - pop_cnt;
  assign fill_d  = base + (accept ? n_in : '0);

  always_comb begin
    flush_d = flush_q;
    if (pop && final_beat) flush_d = 1'b0;
    if (accept && tlast_in) flush_d = 1'b1;
  end

  for (genvar g = 0; g < 2*DATA_BYTES; g++) begin : g_slot
    stream_byte_packer_slot #(
      .DATA_BYTES(DATA_BYTES), .IDX(g), .CW(CW)
    ) u_slot (
      .buf_q (buf_q),
      .din   (data_in),
      .shift (pop_cnt),
      .base  (base),
      .n     (n_in),
      .accept(accept),
      .nxt   (buf_d[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q   <= '0;
      fill_q  <= '0;
      flush_q <= 1'b0;
    end else if (wrt_en) begin
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_stream_byte_packer.sv
// Bench for stream_byte_packer: directed packet cases plus randomized traffic
// checked every cycle against a byte-queue model of the packing rules.

module tb_stream_byte_packer;
  localparam int DB = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            wrt_en;
  logic [8*DB-1:0] data_in;
  logic [DB-1:0]   tkeep_in;
  logic            tvalid_in, tlast_in;
  logic            tready_out;
  logic [8*DB-1:0] data_out;
  logic [DB-1:0]   tkeep_out;
  logic            tvalid_out, tlast_out;
  logic            tready_in;

  stream_byte_packer #(.DATA_BYTES(DB)) dut (
    .clk(clk), .reset(reset), .wrt_en(wrt_en),
    .data_in(data_in), .tkeep_in(tkeep_in), .tvalid_in(tvalid_in), .tlast_in(tlast_in),
    .tready_out(tready_out),
    .data_out(data_out), .tkeep_out(tkeep_out), .tvalid_out(tvalid_out), .tlast_out(tlast_out),
    .tready_in(tready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*DB-1:0] d;
    logic [DB-1:0]   k;
    logic            l;
  } beat_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];     // accepted bytes not yet popped
  int         lens[$];  // remaining byte counts of packets whose tlast was accepted
  int         open_cnt; // bytes of the still-open packet not yet popped
  beat_t      log_q[$];

  task automatic chk(input string nm, input logic [8*DB-1:0] act, input logic [8*DB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DB-1:0] kmask(input int k);
    logic [DB-1:0] m = '0;
    for (int i = 0; i < DB; i++) if (i < k) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [8*DB-1:0] bmask(input int k);
    logic [8*DB-1:0] m = '0;
    for (int i = 0; i < DB; i++) if (i < k) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [8*DB-1:0] mkbeat(input int start);
    logic [8*DB-1:0] d;
    for (int i = 0; i < DB; i++) d[8*i +: 8] = 8'(start + i);
    return d;
  endfunction

  // Model: a packet leaves in 32-byte beats; the beat that exhausts an ended
  // packet carries its remainder (possibly 0 bytes) and tlast.
  logic            e_valid, e_ready, e_final, m_pop, m_acc;
  int              e_k, n_model;
  logic [8*DB-1:0] e_data;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_tvalid", 256'(tvalid_out), 256'(0));
      chk("rst_tready", 256'(tready_out), 256'(0));
      chk("rst_tkeep",  256'(tkeep_out),  256'(0));
      chk("rst_tlast",  256'(tlast_out),  256'(0));
      chk("rst_data",   data_out,         256'(0));
      q.delete(); lens.delete(); open_cnt = 0;
    end else begin
      e_valid = wrt_en && (q.size() >= DB || lens.size() > 0);
      e_ready = wrt_en && lens.size() == 0 && q.size() <= DB;
      chk("tvalid_out", 256'(tvalid_out), 256'(e_valid));
      chk("tready_out", 256'(tready_out), 256'(e_ready));
      if (e_valid) begin
        e_final = lens.size() > 0 && lens[0] <= DB;
        e_k     = e_final ? lens[0] : DB;
        e_data  = '0;
        for (int i = 0; i < e_k; i++) e_data[8*i +: 8] = q[i];
        chk("tkeep_out", 256'(tkeep_out), 256'(kmask(e_k)));
        chk("tlast_out", 256'(tlast_out), 256'(e_final));
        chk("data_out",  data_out & bmask(e_k), e_data);
      end
      m_pop = e_valid && tready_in;
      m_acc = tvalid_in && e_ready;
      if (m_pop) begin
        log_q.push_back('{d: data_out, k: tkeep_out, l: tlast_out});
        for (int i = 0; i < e_k; i++) void'(q.pop_front());
        if (e_final)               void'(lens.pop_front());
        else if (lens.size() > 0)  lens[0] -= DB;
        else                       open_cnt -= DB;
      end
      if (m_acc) begin
        n_model = 0;
        while (n_model < DB && tkeep_in[n_model]) n_model++;
        for (int i = 0; i < n_model; i++) q.push_back(data_in[8*i +: 8]);
        open_cnt += n_model;
        if (tlast_in) begin
          lens.push_back(open_cnt);
          open_cnt = 0;
        end
      end
    end
  end

  task automatic send(input logic [8*DB-1:0] d, input logic [DB-1:0] k, input logic l);
    int t = 0;
    tvalid_in = 1'b1; data_in = d; tkeep_in = k; tlast_in = l;
    @(negedge clk);
    while (!tready_out && t < 100) begin t++; @(negedge clk); end
    if (t >= 100) chk("send_timeout", 256'(1), 256'(0));
    @(posedge clk); #1;
    tvalid_in = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || lens.size() != 0) && t < 200) begin
      t++; @(posedge clk); #1;
    end
    if (t >= 200) chk("drain_timeout", 256'(1), 256'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string nm, input int idx, input int nbytes, input logic l, input int start);
    if (idx >= log_q.size()) chk({nm, "_missing"}, 256'(0), 256'(1));
    else begin
      chk({nm, "_keep"}, 256'(log_q[idx].k), 256'(kmask(nbytes)));
      chk({nm, "_last"}, 256'(log_q[idx].l), 256'(l));
      chk({nm, "_data"}, log_q[idx].d & bmask(nbytes), mkbeat(start) & bmask(nbytes));
    end
  endtask

  logic [63:0] m64, hi64;
  logic [31:0] junk;
  int          nr;

  initial begin
    reset = 1'b0; wrt_en = 1'b1; data_in = '0; tkeep_in = '0;
    tvalid_in = 1'b0; tlast_in = 1'b0; tready_in = 1'b1; open_cnt = 0;
    #3;
    chk("init_tvalid", 256'(tvalid_out), 256'(0));
    chk("init_tready", 256'(tready_out), 256'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Two 16-byte beats make one full final beat
    log_q.delete();
    send(mkbeat(0), 32'h0000FFFF, 1'b0);
    send(mkbeat(16), 32'h0000FFFF, 1'b1);
    drain();
    chk("t16_count", 256'(log_q.size()), 256'(1));
    chk_beat("t16_b0", 0, 32, 1'b1, 0);

    // Two 24-byte beats: full beat then 16-byte tail
    log_q.delete();
    send(mkbeat(0), 32'h00FFFFFF, 1'b0);
    send(mkbeat(24), 32'h00FFFFFF, 1'b1);
    drain();
    chk("t24x2_count", 256'(log_q.size()), 256'(2));
    chk_beat("t24x2_b0", 0, 32, 1'b0, 0);
    chk_beat("t24x2_b1", 1, 16, 1'b1, 32);

    // Three 24-byte beats: 72 bytes -> 32 + 32 + 8
    log_q.delete();
    send(mkbeat(0), 32'h00FFFFFF, 1'b0);
    send(mkbeat(24), 32'h00FFFFFF, 1'b0);
    send(mkbeat(48), 32'h00FFFFFF, 1'b1);
    drain();
    chk("t24x3_count", 256'(log_q.size()), 256'(3));
    chk_beat("t24x3_b0", 0, 32, 1'b0, 0);
    chk_beat("t24x3_b1", 1, 32, 1'b0, 32);
    chk_beat("t24x3_b2", 2, 8, 1'b1, 64);

    // Zero-byte packet
    log_q.delete();
    send(mkbeat(0), 32'h0, 1'b1);
    drain();
    chk("zero_count", 256'(log_q.size()), 256'(1));
    chk_beat("zero_b0", 0, 0, 1'b1, 0);

    // Non-contiguous keep: only the leading run of 3 counts
    log_q.delete();
    send(mkbeat(8'hA0), 32'h000000F7, 1'b1);
    drain();
    chk("f7_count", 256'(log_q.size()), 256'(1));
    chk_beat("f7_b0", 0, 3, 1'b1, 8'hA0);

    // Backpressure: buffer fills to 64 and stalls input
    log_q.delete();
    tready_in = 1'b0;
    send(mkbeat(0), '1, 1'b0);
    send(mkbeat(32), '1, 1'b0);
    @(negedge clk);
    chk("bp_tready_full", 256'(tready_out), 256'(0));
    chk("bp_tvalid_full", 256'(tvalid_out), 256'(1));
    @(posedge clk); #1;
    tready_in = 1'b1;
    send(mkbeat(64), '1, 1'b1);
    drain();
    chk("bp_count", 256'(log_q.size()), 256'(3));
    chk_beat("bp_b0", 0, 32, 1'b0, 0);
    chk_beat("bp_b1", 1, 32, 1'b0, 32);
    chk_beat("bp_b2", 2, 32, 1'b1, 64);

    // Mid-packet reset with 40 bytes held
    tready_in = 1'b0;
    send(mkbeat(0), '1, 1'b0);
    send(mkbeat(32), 32'h000000FF, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mrst_tvalid", 256'(tvalid_out), 256'(0));
    chk("mrst_tready", 256'(tready_out), 256'(0));
    chk("mrst_tkeep",  256'(tkeep_out),  256'(0));
    chk("mrst_tlast",  256'(tlast_out),  256'(0));
    chk("mrst_data",   data_out,         256'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    log_q.delete();
    tready_in = 1'b1;
    send(mkbeat(8'h50), 32'h000000FF, 1'b1);
    drain();
    chk("post_rst_count", 256'(log_q.size()), 256'(1));
    chk_beat("post_rst_b0", 0, 8, 1'b1, 8'h50);

    // Randomized traffic with enable gaps and backpressure
    for (int c = 0; c < 3000; c++) begin
      wrt_en    = ($urandom % 10) != 0;
      tvalid_in = ($urandom % 4) != 0;
      tready_in = ($urandom % 4) != 0;
      tlast_in  = ($urandom % 6) == 0;
      nr        = (c % 200 < 40) ? 32 : int'($urandom % 33);
      m64       = (64'h1 << nr) - 64'h1;
      hi64      = ~((64'h1 << (nr + 1)) - 64'h1);
      junk      = ($urandom % 2) != 0 ? $urandom : 32'h0;
      tkeep_in  = m64[31:0] | (junk & hi64[31:0]);
      for (int w = 0; w < 8; w++) data_in[32*w +: 32] = $urandom;
      @(posedge clk); #1;
    end
    wrt_en = 1'b1; tready_in = 1'b1; tvalid_in = 1'b0;
    send(mkbeat(0), 32'h0, 1'b1);
    drain();
    chk("final_empty", 256'(q.size() + lens.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
